// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider.
// Each channel counts clk_in_i cycles up to its active divisor and emits either a 50% square
// wave (toggle mode) or a one-cycle tick (pulse mode). New settings are written to a shadow
// and only take effect when the counter restarts, so outputs never glitch mid-period.
module clk_divider_multi #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 49
) (
  input  logic             clk_in_i,
  input  logic             reset_ni,
  input  logic [N_CH-1:0]  en_i,
  input  logic             sync_i,
  input  logic             cfg_wr_i,
  input  logic [3:0]       cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  output logic [N_CH-1:0]  clk_out_o,
  output logic [N_CH-1:0]  pending_o,
  output logic             cfg_err_o
);

  localparam logic [CNT_W-1:0] DefDiv  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CntZero = '0;
  localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [CNT_W-1:0] act_div_q [N_CH];
  logic [CNT_W-1:0] act_div_d [N_CH];
  logic [CNT_W-1:0] sh_div_q  [N_CH];
  logic [CNT_W-1:0] sh_div_d  [N_CH];
  logic [N_CH-1:0]  act_mode_q, act_mode_d;
  logic [N_CH-1:0]  sh_mode_q, sh_mode_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic             cfg_err_q, cfg_err_d;

  logic [N_CH-1:0]  wrap;
  logic [N_CH-1:0]  restart;
  logic [N_CH-1:0]  apply;
  logic [N_CH-1:0]  wr_hit;

  // Per-channel events: wrap, forced restart (sync/disable), shadow apply, config hit.
  always_comb begin
    wrap    = '0;
    restart = '0;
    apply   = '0;
    wr_hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      wrap[i]    = en_i[i] && (cnt_q[i] == act_div_q[i]);
      restart[i] = sync_i || !en_i[i];
      apply[i]   = pend_q[i] && (restart[i] || wrap[i]);
      wr_hit[i]  = cfg_wr_i && (int'(cfg_ch_i) == i);
    end
  end

  // Next-state for counters, outputs and the active/shadow configuration.
  always_comb begin
    cfg_err_d  = cfg_wr_i && (int'(cfg_ch_i) >= int'(N_CH));
    act_mode_d = act_mode_q;
    sh_mode_d  = sh_mode_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]     = cnt_q[i];
      act_div_d[i] = act_div_q[i];
      sh_div_d[i]  = sh_div_q[i];

      if (restart[i]) begin
        cnt_d[i] = CntZero;
        clk_d[i] = 1'b0;
      end else if (wrap[i]) begin
        cnt_d[i] = CntZero;
        // A mode switch starts the new mode from a clean low level.
        if (apply[i] && (sh_mode_q[i] != act_mode_q[i])) begin
          clk_d[i] = 1'b0;
        end else if (act_mode_q[i]) begin
          clk_d[i] = 1'b1;
        end else begin
          clk_d[i] = ~clk_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
        if (act_mode_q[i]) begin
          clk_d[i] = 1'b0;
        end
      end

      // Apply consumes the pre-edge shadow; a same-edge write re-arms pending below.
      if (apply[i]) begin
        act_div_d[i]  = sh_div_q[i];
        act_mode_d[i] = sh_mode_q[i];
        pend_d[i]     = 1'b0;
      end
      if (wr_hit[i]) begin
        sh_div_d[i]  = cfg_div_i;
        sh_mode_d[i] = cfg_mode_i;
        pend_d[i]    = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= CntZero;
        act_div_q[i] <= DefDiv;
        sh_div_q[i]  <= DefDiv;
      end
      act_mode_q <= '0;
      sh_mode_q  <= '0;
      pend_q     <= '0;
      clk_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]     <= cnt_d[i];
        act_div_q[i] <= act_div_d[i];
        sh_div_q[i]  <= sh_div_d[i];
      end
      act_mode_q <= act_mode_d;
      sh_mode_q  <= sh_mode_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign clk_out_o = clk_q;
  assign pending_o = pend_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed, table-driven bench for clk_divider_multi (N_CH=2, CNT_W=16, DEF_DIV=49).
// Each vector drives inputs, advances a number of clk edges (config/sync strobes only on the
// first edge), then compares clk_out, pending and cfg_err against hand-computed values.
module tb_clk_divider_multi;

  logic        clk;
  logic        reset_n;
  logic [1:0]  en;
  logic        sync;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [1:0]  clk_out;
  logic [1:0]  pending;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  clk_divider_multi #(
    .N_CH    (2),
    .CNT_W   (16),
    .DEF_DIV (49)
  ) dut (
    .clk_in_i   (clk),
    .reset_ni   (reset_n),
    .en_i       (en),
    .sync_i     (sync),
    .cfg_wr_i   (cfg_wr),
    .cfg_ch_i   (cfg_ch),
    .cfg_div_i  (cfg_div),
    .cfg_mode_i (cfg_mode),
    .clk_out_o  (clk_out),
    .pending_o  (pending),
    .cfg_err_o  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          adv;
    logic [1:0]  en;
    logic        sy;
    logic        wr;
    logic [3:0]  ch;
    logic [15:0] dv;
    logic        md;
    logic [1:0]  eclk;
    logic [1:0]  epend;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int adv, input logic [1:0] e, input logic sy,
                              input logic wr, input logic [3:0] ch, input logic [15:0] dv,
                              input logic md, input logic [1:0] ec, input logic [1:0] ep,
                              input logic ee);
    vec_t v;
    v.adv = adv; v.en = e; v.sy = sy; v.wr = wr; v.ch = ch; v.dv = dv; v.md = md;
    v.eclk = ec; v.epend = ep; v.eerr = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 2'b11;
    sync     = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = 4'd0;
    cfg_div  = 16'd0;
    cfg_mode = 1'b0;

    // Comments give the edge count since reset release after each vector.
    // Default D=49 toggle on both channels: period 100.
    add(49, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 49
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 50
    add(49, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 99
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 100
    add(50, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 150
    add(10, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 160
    // ch1 -> D=4 toggle mid-period; applies at ch1's wrap on edge 200.
    add(1,  2'b11, 0, 1, 4'd1, 16'd4, 0, 2'b11, 2'b10, 0); // 161
    add(38, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b10, 0); // 199
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 200
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 204
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 205
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 209
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 210
    add(39, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 249
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 250
    // ch0 -> D=9 pulse; mode change forces low at apply (edge 300), ticks at 310, 320.
    add(1,  2'b11, 0, 1, 4'd0, 16'd9, 1, 2'b01, 2'b01, 0); // 251
    add(48, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b01, 0); // 299
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 300
    add(9,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 309
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 310
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 311
    add(9,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 320
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 321
    // Invalid channel: one-cycle error, no pending change.
    add(1,  2'b11, 0, 1, 4'd5, 16'd2, 1, 2'b00, 2'b00, 1); // 322
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 323
    // ch0 -> D=0 pulse: constant high after apply at 330.
    add(1,  2'b11, 0, 1, 4'd0, 16'd0, 1, 2'b00, 2'b01, 0); // 324
    add(5,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b01, 0); // 329
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 330
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 331
    add(13, 2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 344
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 345
    // ch1: shadow 7 pending, rewrite 3 on the exact wrap edge 350.
    add(1,  2'b11, 0, 1, 4'd1, 16'd7, 0, 2'b11, 2'b10, 0); // 346
    add(3,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b10, 0); // 349
    add(1,  2'b11, 0, 1, 4'd1, 16'd3, 0, 2'b01, 2'b10, 0); // 350
    add(7,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b10, 0); // 357
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 358
    add(3,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 361
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 362
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 366
    // ch0 -> D=4 toggle, ch1 -> D=9 toggle, running out of phase.
    add(1,  2'b11, 0, 1, 4'd0, 16'd4, 0, 2'b11, 2'b01, 0); // 367
    add(1,  2'b11, 0, 1, 4'd1, 16'd9, 0, 2'b10, 2'b10, 0); // 368
    add(2,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 370
    add(3,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 373
    add(5,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 378
    add(2,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 380
    add(2,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 382
    add(1,  2'b11, 0, 1, 4'd0, 16'd4, 0, 2'b11, 2'b01, 0); // 383
    // sync: everything low, pending consumed, then aligned restart.
    add(1,  2'b11, 1, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 384
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 388
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 389
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 393
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 394
    add(5,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 399
    add(5,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b00, 2'b00, 0); // 404
    add(5,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 409
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b01, 2'b00, 0); // 413
    // Disable ch0 for one edge while high, then re-enable.
    add(1,  2'b10, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 414
    add(4,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b10, 2'b00, 0); // 418
    add(1,  2'b11, 0, 0, 4'd0, 16'd0, 0, 2'b11, 2'b00, 0); // 419
    add(1,  2'b11, 0, 1, 4'd1, 16'd2, 1, 2'b11, 2'b10, 0); // 420

    // Reset state while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_out", 32'(clk_out), 32'(2'b00));
    check("rst_pending", 32'(pending), 32'(2'b00));
    check("rst_cfg_err", 32'(cfg_err), 32'(1'b0));
    reset_n = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      en       = vecs[v].en;
      sync     = vecs[v].sy;
      cfg_wr   = vecs[v].wr;
      cfg_ch   = vecs[v].ch;
      cfg_div  = vecs[v].dv;
      cfg_mode = vecs[v].md;
      for (int s = 0; s < vecs[v].adv; s++) begin
        step();
        cfg_wr = 1'b0;
        sync   = 1'b0;
      end
      check($sformatf("vec%0d_clk_out", v), 32'(clk_out), 32'(vecs[v].eclk));
      check($sformatf("vec%0d_pending", v), 32'(pending), 32'(vecs[v].epend));
      check($sformatf("vec%0d_cfg_err", v), 32'(cfg_err), 32'(vecs[v].eerr));
    end

    // Asynchronous reset mid-period clears outputs without waiting for a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'(2'b00));
    check("async_rst_pending", 32'(pending), 32'(2'b00));
    check("async_rst_cfg_err", 32'(cfg_err), 32'(1'b0));

    // After release the default divisor is back in force on both channels.
    step();
    reset_n = 1'b1;
    en      = 2'b11;
    repeat (49) step();
    check("post_rst_clk_49", 32'(clk_out), 32'(2'b00));
    step();
    check("post_rst_clk_50", 32'(clk_out), 32'(2'b11));
    check("post_rst_pending", 32'(pending), 32'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Parametrised multi-channel clock divider for the board clock domain. Each of `N_CH` independent channels divides `clk_in` by a runtime-programmable divisor and produces either a 50% square wave or a one-cycle tick. A configuration port allows safe runtime reprogramming: new settings are shadowed and applied only at a period boundary, so no output glitches. A common `sync` input phase-aligns all channels.

## Interface
- `N_CH`, 2: number of divider channels (1..16).
- `CNT_W`, 16: divisor/counter width in bits.
- `DEF_DIV`, 49: reset divisor for every channel (must fit in `CNT_W`).
- `clk_in`  in  1  system clock.
- `reset`  in  1  reset; asynchronous, active-low.
- `en`  in  N_CH  per-channel enable, level.
- `sync`  in  1  single-cycle pulse; restarts all channels in phase.
- `cfg_wr`  in  1  single-cycle configuration write strobe.
- `cfg_ch`  in  4  target channel index for `cfg_wr`.
- `cfg_div`  in  CNT_W  new divisor D.
- `cfg_mode`  in  1  new mode: 0 = toggle (square), 1 = pulse (tick).
- `clk_out`  out  N_CH  per-channel divided output, registered.
- `pending`  out  N_CH  per-channel flag: shadow config not yet applied.
- `cfg_err`  out  1  one-cycle pulse: `cfg_wr` with `cfg_ch >= N_CH`.

## Operation
- Per-channel state: `cnt` (CNT_W), `act_div`, `act_mode`, `sh_div`, `sh_mode`, `pending`, `clk_out`.
- Reset (asserted low, async): `cnt=0`, `act_div=sh_div=DEF_DIV`, `act_mode=sh_mode=0`, `pending=0`, `clk_out=0`, `cfg_err=0`.
- Wrap event for a channel: `en[i]=1` and `cnt==act_div`.
- Enabled, no wrap: `cnt<=cnt+1`; pulse mode drives `clk_out<=0`, toggle mode holds.
- At wrap: `cnt<=0`; toggle mode `clk_out<=~clk_out`; pulse mode `clk_out<=1`.
- Period: toggle mode = 2·(D+1) `clk_in` cycles, 50% duty; pulse mode = tick every D+1 cycles, high 1 cycle. D=0: toggle gives `clk_in`/2; pulse holds `clk_out` constantly high.
- Config write (`cfg_wr=1`, `cfg_ch<N_CH`): `sh_div<=cfg_div`, `sh_mode<=cfg_mode`, `pending[cfg_ch]<=1`. Rewrites before application overwrite the shadow (last write wins).
- Invalid channel (`cfg_ch>=N_CH`): no state change; `cfg_err<=1` for one cycle.
- Application: when a wrap occurs with `pending=1`: `act_div<=sh_div`, `act_mode<=sh_mode`, `pending<=0`, `cnt<=0`. The wrap-edge output update uses the old mode. If the mode changes, `clk_out<=0` instead of the normal wrap update.
- Disabled (`en[i]=0`): `cnt<=0`, `clk_out<=0`; any pending shadow applies on the next edge.
- `sync=1`: every channel `cnt<=0`, `clk_out<=0`, pending shadow applied. This overrides wrap and enable.
- Simultaneous `cfg_wr` and wrap/apply on the same channel:
  - Apply uses the shadow value present before the edge.
  - The new write lands in the shadow, and `pending` stays 1.
  - With no prior pending, the wrap proceeds normally and the new write becomes pending.
- Counter compare is equality only. `cnt` never exceeds `act_div` because `act_div` changes only when `cnt` is cleared.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `cfg_wr` at edge k: `pending` high after edge k; `cfg_err` high for the cycle after edge k.
- New divisor takes effect from the first wrap after the write: worst case `act_div`+1 cycles of delay.
- `en` rising at edge k: first wrap at edge k+`act_div`+1.
- `sync` at edge k: all enabled channels wrap together at edge k+`act_div[i]`+1.
- Reset deassertion is synchronised externally. The first count edge is the first `clk_in` edge with reset high.

## Test plan
- Reset, `en=2'b11`, D=DEF_DIV=49 on both channels, toggle mode -> `clk_out` toggles every 50 cycles (period 100); `pending=0`, `cfg_err=0`.
- Write ch1 `cfg_div=4`, `cfg_mode=0` mid-period -> `pending[1]=1` until ch1's next wrap, then toggles every 5 cycles; ch0 unaffected; no pulse shorter than 5 cycles.
- Write ch0 `cfg_div=9`, `cfg_mode=1` -> after apply, `clk_out[0]` is forced 0, then high exactly 1 cycle every 10 cycles; D=0 in pulse mode -> constant 1.
- `cfg_wr` with `cfg_ch=5` (N_CH=2) -> `cfg_err` high for exactly 1 cycle; shadows and `pending` unchanged.
- `cfg_wr` on the exact wrap cycle while pending (old shadow 7, new 3) -> period uses 7, `pending` stays 1, next wrap switches to 3.
- `sync` pulse with ch0 D=4, ch1 D=9 running out of phase -> both `clk_out=0` and `cnt=0`, then rising edges coincide every 20 cycles; async reset asserted mid-period -> all outputs 0 immediately.
